// File: rtl/dpe_csa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : dpe_csa_pkg                                                  |
// | Description : Shared defaults and elaboration-time helpers for the         |
// |               carry-save reduction / accumulation path.                    |
// |               csa_rows   - rows left after a given number of 3:2 levels    |
// |               csa_levels - 3:2 levels needed to reach two rows             |
// |               out_w      - accumulated result width                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dpe_csa_pkg;

  localparam int N_IN_DEF     = 8;
  localparam int WIDTH_DEF    = 16;
  localparam int ACC_BITS_DEF = 8;

  // Each level turns every complete group of three rows into two rows and
  // passes the leftover (0..2) rows straight through.
  function automatic int csa_rows(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++) begin
      r = 2 * (r / 3) + (r % 3);
    end
    return r;
  endfunction

  function automatic int csa_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (r > 2) begin
        r = 2 * (r / 3) + (r % 3);
        l = l + 1;
      end
    end
    return l;
  endfunction

  function automatic int out_w(input int width, input int n, input int acc_bits);
    return width + $clog2(n) + acc_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csa_3_2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : csa_3_2                                                      |
// | Description : Purely combinational row of 3:2 compressors.                 |
// |               a, b, c  in  [WIDTH-1:0]  three addend rows                  |
// |               sum      out [WIDTH-1:0]  bitwise a^b^c                      |
// |               carry    out [WIDTH-1:0]  majority(a,b,c) shifted left by 1  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module csa_3_2 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] w_maj;

  assign w_maj = (a & b) | (a & c) | (b & c);
  assign sum   = a ^ b ^ c;
  // The majority MSB falls off the top; the tree is sized so the true total
  // always fits, so sum+carry stays correct modulo 2^WIDTH.
  assign carry = w_maj << 1;

endmodule
`default_nettype wire

// File: rtl/csa_accum_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : csa_accum_pipe                                               |
// | Description : Three-stage pipelined carry-save reduction of N_IN unsigned  |
// |               operands per beat, followed by a multi-beat accumulator.     |
// |               One result per group; a group ends on the beat with in_last. |
// | Ports       : clk, rst (async, active high)                                |
// |               in_valid/in_ready/in_data/in_last   - input beat handshake   |
// |               out_valid/out_ready                 - result handshake       |
// |               out_sum   [OUT_W-1:0] group sum modulo 2^OUT_W               |
// |               out_count [CNT_W-1:0] beats in group, saturating             |
// |               out_ovf               group sum exceeded 2^OUT_W-1           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module csa_accum_pipe
  import dpe_csa_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int ACC_BITS = ACC_BITS_DEF,
  parameter int OUT_W    = out_w(WIDTH, N_IN, ACC_BITS),
  parameter int CNT_W    = ACC_BITS + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0][WIDTH-1:0] in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_sum,
  output logic [CNT_W-1:0]           out_count,
  output logic                       out_ovf
);

  localparam int c_tree_w    = WIDTH + $clog2(N_IN);
  localparam int c_levels    = csa_levels(N_IN);
  localparam int c_s1_levels = (c_levels + 1) / 2;
  localparam int c_s1_rows   = csa_rows(N_IN, c_s1_levels);

  logic w_stall;
  logic w_accept;

  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;
  assign w_accept = in_valid && in_ready;

  // w_lvl[k] : rows produced by level k-1 (w_lvl[0] is the input beat).
  // w_src[k] : rows consumed by level k; at the stage boundary these come
  //            from the S1 register instead of the combinational chain.
  logic [c_tree_w-1:0] w_lvl [0:c_levels][0:N_IN-1];
  logic [c_tree_w-1:0] w_src [0:c_levels][0:N_IN-1];
  logic [c_tree_w-1:0] r_s1_rows [0:c_s1_rows-1];

  logic                r_s1_valid;
  logic                r_s1_last;
  logic                r_s2_valid;
  logic                r_s2_last;
  logic [c_tree_w-1:0] r_s2_save;
  logic [c_tree_w-1:0] r_s2_carry;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign w_lvl[0][i] = c_tree_w'(in_data[i]);
  end

  for (genvar k = 0; k <= c_levels; k++) begin : g_src
    for (genvar i = 0; i < N_IN; i++) begin : g_row
      if (k == c_s1_levels) begin : g_reg
        if (i < c_s1_rows) begin : g_used
          assign w_src[k][i] = r_s1_rows[i];
        end else begin : g_unused
          assign w_src[k][i] = '0;
        end
      end else begin : g_comb
        assign w_src[k][i] = w_lvl[k][i];
      end
    end
  end

  for (genvar k = 0; k < c_levels; k++) begin : g_tree
    localparam int c_rin = csa_rows(N_IN, k);
    localparam int c_grp = c_rin / 3;
    localparam int c_rem = c_rin % 3;

    for (genvar g = 0; g < c_grp; g++) begin : g_csa
      logic [c_tree_w-1:0] w_s;
      logic [c_tree_w-1:0] w_c;

      csa_3_2 #(
        .WIDTH (c_tree_w)
      ) u_csa (
        .a     (w_src[k][3*g]),
        .b     (w_src[k][3*g+1]),
        .c     (w_src[k][3*g+2]),
        .sum   (w_s),
        .carry (w_c)
      );

      assign w_lvl[k+1][2*g]   = w_s;
      assign w_lvl[k+1][2*g+1] = w_c;
    end

    for (genvar r = 0; r < c_rem; r++) begin : g_pass
      assign w_lvl[k+1][2*c_grp+r] = w_src[k][3*c_grp+r];
    end

    for (genvar i = 2*c_grp + c_rem; i < N_IN; i++) begin : g_zero
      assign w_lvl[k+1][i] = '0;
    end
  end

  // S1: first half of the compressor levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      for (int i = 0; i < c_s1_rows; i++) begin
        r_s1_rows[i] <= '0;
      end
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      r_s1_last  <= in_valid && in_last;
      if (w_accept) begin
        for (int i = 0; i < c_s1_rows; i++) begin
          r_s1_rows[i] <= w_lvl[c_s1_levels][i];
        end
      end
    end
  end

  // S2: remaining levels, captured as a save/carry pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_save  <= '0;
      r_s2_carry <= '0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      if (r_s1_valid) begin
        r_s2_save  <= w_src[c_levels][0];
        r_s2_carry <= w_src[c_levels][1];
      end
    end
  end

  // OUT stage: carry-propagate add and accumulate.
  logic [OUT_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;
  logic                r_first;

  logic [c_tree_w-1:0] w_pair_sum;
  logic [OUT_W:0]      w_beat_sum;
  logic [OUT_W:0]      w_acc_base;
  logic [OUT_W:0]      w_acc_sum;
  logic [OUT_W-1:0]    w_acc_next;
  logic                w_ovf_next;
  logic [CNT_W-1:0]    w_cnt_next;

  // The pair is added at tree width on purpose: an individual save+carry can
  // exceed 2^c_tree_w, but their sum modulo 2^c_tree_w is the exact beat total.
  assign w_pair_sum = r_s2_save + r_s2_carry;
  assign w_beat_sum = (OUT_W+1)'(w_pair_sum);
  assign w_acc_base = r_first ? '0 : {1'b0, r_acc};
  assign w_acc_sum  = w_acc_base + w_beat_sum;
  assign w_acc_next = w_acc_sum[OUT_W-1:0];
  assign w_ovf_next = (!r_first && r_ovf) || w_acc_sum[OUT_W];
  assign w_cnt_next = r_first ? CNT_W'(1) :
                      (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_first   <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (!w_stall) begin
      if (r_s2_valid) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
        r_ovf <= w_ovf_next;
        if (r_s2_last) begin
          out_sum   <= w_acc_next;
          out_count <= w_cnt_next;
          out_ovf   <= w_ovf_next;
          out_valid <= 1'b1;
          r_first   <= 1'b1;
        end else begin
          out_valid <= 1'b0;
          r_first   <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csa_accum_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_csa_accum_pipe                                            |
// | Description : Directed self-checking bench for csa_accum_pipe with         |
// |               N_IN=8, WIDTH=16, ACC_BITS=8 (OUT_W=27, CNT_W=9).            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_csa_accum_pipe;

  localparam int N_IN     = 8;
  localparam int WIDTH    = 16;
  localparam int ACC_BITS = 8;
  localparam int OUT_W    = 27;
  localparam int CNT_W    = 9;

  typedef logic [N_IN-1:0][WIDTH-1:0] beat_t;
  typedef struct {
    logic [OUT_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  beat_t            in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t got_q[$];
  res_t exp_q[$];

  csa_accum_pipe #(
    .N_IN     (N_IN),
    .WIDTH    (WIDTH),
    .ACC_BITS (ACC_BITS)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Record every result that will transfer on the coming rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_q.push_back('{sum: out_sum, cnt: out_count, ovf: out_ovf});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic beat_t fill(input logic [WIDTH-1:0] v);
    beat_t d;
    for (int i = 0; i < N_IN; i++) d[i] = v;
    return d;
  endfunction

  // Called and returns at 1 time unit after a rising edge.
  task automatic send(input beat_t d, input logic last);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_res(input logic [OUT_W-1:0] s, input logic [CNT_W-1:0] c,
                            input logic o);
    exp_q.push_back('{sum: s, cnt: c, ovf: o});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 1000 && got_q.size() < exp_q.size(); i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk({tag, "_count_of_results"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_r%0d_sum", tag, i), 64'(got_q[i].sum), 64'(exp_q[i].sum));
      chk($sformatf("%s_r%0d_cnt", tag, i), 64'(got_q[i].cnt), 64'(exp_q[i].cnt));
      chk($sformatf("%s_r%0d_ovf", tag, i), 64'(got_q[i].ovf), 64'(exp_q[i].ovf));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    beat_t d;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum",   64'(out_sum),   64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_ovf",   64'(out_ovf),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);

    // Single beat of all-ones: latency and max single-beat sum.
    send(fill(16'hFFFF), 1'b1);
    chk("lat_e0_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_e1_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_e2_valid", 64'(out_valid), 64'd1);
    chk("lat_e2_sum",   64'(out_sum),   64'd524280);
    chk("lat_e2_count", 64'(out_count), 64'd1);
    chk("lat_e2_ovf",   64'(out_ovf),   64'd0);
    expect_res(27'd524280, 9'd1, 1'b0);
    drain("single");

    // Four beats of 1..8, one result only.
    for (int i = 0; i < N_IN; i++) d[i] = WIDTH'(i + 1);
    for (int b = 0; b < 4; b++) send(d, b == 3);
    expect_res(27'd144, 9'd4, 1'b0);
    drain("four_beat");

    // Backpressure: three single-beat groups while the consumer stalls.
    out_ready = 1'b0;
    d = fill(16'd1); d[6] = 16'd2; d[7] = 16'd2;
    send(d, 1'b1);
    d = fill(16'd2); for (int i = 4; i < 8; i++) d[i] = 16'd3;
    send(d, 1'b1);
    d = fill(16'd3); d[4] = 16'd4; d[5] = 16'd4; d[6] = 16'd5; d[7] = 16'd5;
    send(d, 1'b1);
    chk("stall_in_ready", 64'(in_ready),  64'd0);
    chk("stall_valid",    64'(out_valid), 64'd1);
    chk("stall_sum",      64'(out_sum),   64'd10);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_hold_sum",   64'(out_sum),  64'd10);
    chk("stall_hold_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    expect_res(27'd10, 9'd1, 1'b0);
    expect_res(27'd20, 9'd1, 1'b0);
    expect_res(27'd30, 9'd1, 1'b0);
    drain("stall");

    // 257 beats of all-ones: wraps the accumulator, then a clean group.
    for (int b = 0; b < 257; b++) send(fill(16'hFFFF), b == 256);
    send(fill(16'd1), 1'b1);
    expect_res(27'd522232, 9'd257, 1'b1);
    expect_res(27'd8, 9'd1, 1'b0);
    drain("overflow");

    // Async reset with a pending result and a partial group in flight.
    out_ready = 1'b0;
    send(fill(16'd1), 1'b1);
    send(fill(16'd5), 1'b0);
    send(fill(16'd5), 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_sum",   64'(out_sum),   64'd0);
    chk("async_rst_count", 64'(out_count), 64'd0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    got_q.delete();
    @(posedge clk);
    #1;
    send(fill(16'd2), 1'b1);
    expect_res(27'd16, 9'd1, 1'b0);
    drain("after_rst");

    // Back-to-back groups without a bubble.
    send(fill(16'd1), 1'b1);
    send(fill(16'd3), 1'b0);
    send(fill(16'd3), 1'b1);
    expect_res(27'd8, 9'd1, 1'b0);
    expect_res(27'd48, 9'd2, 1'b0);
    drain("b2b");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csa_accum_pipe.md
Name: csa_accum_pipe

Overview:
- Parametrised, pipelined carry-save reduction of an N_IN-element unsigned vector, followed by an optional multi-beat accumulator.
- Used by the DPE column path to sum cell products, and to accumulate partial dot products across several input beats.
- Valid/ready on both sides; one result per group of beats, where a group ends on the beat tagged in_last.

Parameters:
- N_IN, 8, number of input operands per beat (must be >= 3).
- WIDTH, 16, operand width in bits, unsigned.
- ACC_BITS, 8, extra headroom bits for accumulating across beats.
- OUT_W, WIDTH+$clog2(N_IN)+ACC_BITS, result width; derived, never overridden.
- CNT_W, ACC_BITS+1, beat-counter width; derived.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat.
- in_data  in  [N_IN-1:0][WIDTH-1:0]  operands.
- in_last  in  1  beat closes the current group.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  OUT_W  group sum, modulo 2^OUT_W.
- out_count  out  CNT_W  beats in the group; saturates at all-ones.
- out_ovf  out  1  sticky: the group sum exceeded 2^OUT_W-1.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - All stage valid bits, the accumulator, the beat counter and the ovf flag clear.
  - A reset mid-group discards the partial group.
  - in_ready=1 while rst is low and the pipeline is not stalled.
- Stall:
  - stall = out_valid && !out_ready. All stages hold while stall=1.
  - in_ready = !stall, combinational.
  - A beat is accepted only when in_valid && in_ready.
- Pipeline (3 register stages):
  - S1: first ceil(L/2) levels of 3:2 compressors, where L is the number of levels needed to reduce N_IN rows to 2.
  - S2: remaining levels, registered as a save/carry pair.
  - OUT: carry-propagate add plus accumulate.
  - Latency: a beat accepted on edge 0 passes S1 on edge 0, S2 on edge 1 and OUT on edge 2.
  - For a single-beat group, out_valid is high after edge 2.
  - Throughput is 1 beat per cycle when not stalled.
- Accumulation at the OUT stage, on a valid S2 beat:
  - beat_sum = save + carry, computed in OUT_W+1 bits.
  - acc_next = (first ? 0 : acc) + beat_sum. Any carry into bit OUT_W sets ovf_next.
  - ovf_next = (first ? 0 : ovf) | carry_out.
  - cnt_next = first ? 1 : sat(cnt+1).
  - first is 1 after reset and after any last beat, otherwise 0.
- Output register:
  - When the S2 beat carries last: out_sum<=acc_next, out_count<=cnt_next, out_ovf<=ovf_next, out_valid<=1. The accumulator state is then marked first.
  - Otherwise only acc/cnt/ovf update and out_valid is cleared. It is cleared only when !stall, so a pending result is never lost.
  - out_* hold stable while out_valid && !out_ready.
- A last beat followed immediately by the next group's first beat needs no bubble; the new group starts from 0.
- in_last on a beat with in_valid=0 is ignored.
- Arithmetic:
  - All operands are unsigned.
  - The compressor tree carries full width WIDTH+$clog2(N_IN), so a single beat never truncates.
  - Truncation happens only in the accumulator.

Decomposition:
- Package dpe_csa_pkg holds:
  - function csa_levels(n), returning the number of 3:2 levels to reach 2 rows;
  - function out_w(width, n, acc_bits);
  - localparam defaults N_IN_DEF=8, WIDTH_DEF=16, ACC_BITS_DEF=8.
- Sub-module csa_3_2: a width-parameterised, purely combinational 3:2 compressor row (sum = a^b^c, carry = majority shifted left by 1).
  - It is instantiated in a generate loop per level.
  - The top module owns the registers, stall logic and accumulator.

Test Plan (N_IN=8, WIDTH=16, ACC_BITS=8, so OUT_W=27, CNT_W=9):
- Single beat, all operands 16'hFFFF, in_last=1, out_ready=1 → out_valid high after edge 2; out_sum=524280, out_count=1, out_ovf=0.
- Four beats with operands 1..8 (sum 36), in_last only on beat 4 → exactly one out_valid pulse; out_sum=144, out_count=4; no out_valid for beats 1-3.
- Three single-beat groups with sums 10, 20, 30, and out_ready=0 for 5 cycles → in_ready drops after the first result; out_sum is held at 10; results 10, 20, 30 follow in order with no loss or duplication.
- 257 beats of all 16'hFFFF, in_last on beat 257 → out_sum=522232 (134739960 mod 2^27), out_ovf=1, out_count=257. A following single-beat group of all 1s → out_sum=8, out_ovf=0.
- Async reset:
  - Scenario: 2 beats of a group, then rst pulsed between clock edges.
  - out_valid goes to 0 immediately.
  - After release, a group of one beat of all 2s gives out_sum=16, out_count=1.
- Back-to-back groups: group A (one beat of all 1s, last) then group B (two beats of all 3s, last on the second), with no idle cycle → results 8 (count 1) then 48 (count 2).
